npc_sequencer: RTL

Multi-cycle instruction sequencer for the npc RV32 core. It owns the PC and instruction register, steps each instruction through fetch, decode, execute, memory and writeback, and gates the register-file and PC write strobes so the combinational `cu` controls and the datapath are only committed once per instruction. It sits between the instruction/data memory handshakes and the existing single-cycle datapath.

---
 rtl/npc_sequencer.sv | 90 +++++++++
 1 files changed

// File: rtl/npc_sequencer.sv
// npc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC, IR and commit strobes
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_o_seq,
  input  logic        ifu_rvalid_i_seq,
  input  logic [31:0] ifu_rdata_i_seq,
  output logic        lsu_req_o_seq,
  output logic        lsu_we_o_seq,
  input  logic        lsu_done_i_seq,
  input  logic        cu_we_i_seq,
  input  logic [31:0] next_pc_i_seq,
  output logic [31:0] pc_o_seq,
  output logic [31:0] ir_o_seq,
  output logic        rf_we_o_seq,
  output logic        halt_o_seq,
  output logic [1:0]  trap_cause_o_seq,
  output logic [31:0] instret_o_seq,
  output logic [2:0]  state_o_seq
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  logic [2:0] state, state_n;
  logic [1:0] cause_n;
  logic [7:0] cnt;
  logic [6:0] op;
  logic legal, is_store, is_mem, expire;
  assign op       = ir_o_seq[6:0];
  assign is_store = op == 7'b0100011;
  assign is_mem   = is_store || op == 7'b0000011;
  assign legal    = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  assign expire   = cnt + 8'd1 == TIMEOUT;
  assign ifu_req_o_seq = state == FETCH;
  assign lsu_req_o_seq = state == MEM;
  assign lsu_we_o_seq  = lsu_req_o_seq && is_store;
  assign rf_we_o_seq   = state == WB && cu_we_i_seq && !is_store;
  assign state_o_seq   = state;
  always_comb begin
    state_n = state;
    cause_n = trap_cause_o_seq;
    case (state)
      FETCH: begin
        state_n = ifu_rvalid_i_seq ? DECODE : expire ? HALT : FETCH;
        cause_n = !ifu_rvalid_i_seq && expire ? 2'b10 : trap_cause_o_seq;
      end
      DECODE: begin
        state_n = ir_o_seq != EBREAK && legal ? EXEC : HALT;
        cause_n = ir_o_seq == EBREAK ? 2'b00 : legal ? trap_cause_o_seq : 2'b01;
      end
      EXEC: state_n = is_mem ? MEM : WB;
      MEM: begin
        state_n = lsu_done_i_seq ? WB : expire ? HALT : MEM;
        cause_n = !lsu_done_i_seq && expire ? 2'b11 : trap_cause_o_seq;
      end
      WB: state_n = FETCH;
      default: state_n = state;
    endcase
  end
  // the wait counter restarts on every state change so each wait is timed on its own
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FETCH;
      cnt              <= '0;
      pc_o_seq         <= RESET_PC;
      ir_o_seq         <= '0;
      instret_o_seq    <= '0;
      trap_cause_o_seq <= '0;
      halt_o_seq       <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= state_n != state ? 8'd0 : cnt + 8'd1;
      trap_cause_o_seq <= cause_n;
      halt_o_seq       <= state_n == HALT;
      if (state == FETCH && ifu_rvalid_i_seq) ir_o_seq <= ifu_rdata_i_seq;
      if (state == WB) begin
        pc_o_seq      <= next_pc_i_seq;
        instret_o_seq <= instret_o_seq + 32'd1;
      end
    end
  end
endmodule
